affine_batch_seq: RTL
=====================

Name: affine_batch_seq

Overview:
Batch scheduler for the peripheral's fixed-point affine transform engine. It holds up to DEPTH input points and issues them one at a time to the engine through a start/done handshake. Each engine result is written to a result buffer at the same index. When the batch completes, the block raises a sticky done flag and a one-cycle interrupt pulse. It sits between the memory-mapped register file and the single shared engine, so software loads a batch once instead of polling per point.

Parameters:
DEPTH, 8, number of point slots; power of two, 2..16
W, 16, signed coordinate width (two's complement)
TO_CYCLES, 64, engine timeout in cycles; used only with the optional feature

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
pt_we  in  1  write input point slot
pt_idx  in  $clog2(DEPTH)  slot for pt_we
pt_x  in  W  input X
pt_y  in  W  input Y
batch_len  in  $clog2(DEPTH)+1  number of points to process, sampled on go
go  in  1  start batch (one-cycle pulse)
abort  in  1  cancel batch (one-cycle pulse)
eng_start  out  1  one-cycle request to the engine
eng_x  out  W  operand X to the engine, held stable from eng_start to eng_done
eng_y  out  W  operand Y to the engine, held stable from eng_start to eng_done
eng_done  in  1  engine result valid (one-cycle pulse)
eng_ox  in  W  engine result X
eng_oy  in  W  engine result Y
rd_idx  in  $clog2(DEPTH)  result slot select
rd_x  out  W  result X at rd_idx, combinational read
rd_y  out  W  result Y at rd_idx, combinational read
busy  out  1  batch in progress
cur_idx  out  $clog2(DEPTH)  index currently issued
done  out  1  sticky batch-complete flag
irq  out  1  one-cycle pulse on completion
err  out  1  sticky error flag

Behaviour:
- Reset: FSM to IDLE. eng_start=0, busy=0, cur_idx=0, done=0, irq=0, err=0. Point and result buffers are not reset; their reset contents are don't-care.
- FSM states:
  - IDLE -> ISSUE on go when batch_len in 1..DEPTH. go clears done and err and latches len=batch_len.
  - go with batch_len=0 or batch_len>DEPTH: set done=1 and irq=1 next cycle, stay IDLE. Invalid lengths also set err=1.
  - ISSUE (1 cycle): eng_start=1, eng_x/eng_y = point[cur_idx]. Go to WAIT.
  - WAIT: on eng_done, write result[cur_idx] = {eng_ox, eng_oy}.
    - If cur_idx==len-1: go to FINISH.
    - Otherwise: cur_idx+1, go to ISSUE.
  - FINISH (1 cycle): done=1, irq=1, busy=0, cur_idx=0. Go to IDLE.
- busy=1 in ISSUE and WAIT.
- Engine-side timing:
  - Minimum per-point cost is 2 cycles plus engine latency.
  - eng_done arriving in the same cycle as eng_start is ignored.
  - eng_done seen in IDLE is ignored.
- go while busy: ignored.
- abort while busy: return to IDLE next cycle, busy=0, cur_idx=0, err=1, done stays 0. Results already written are retained. An engine done arriving later is ignored.
- abort and go in the same cycle while IDLE: abort wins, no batch starts.
- abort and eng_done in the same cycle: abort wins; the result is not written.
- pt_we while busy:
  - Writes are accepted.
  - A write to a slot index > cur_idx affects the current batch.
  - A write to cur_idx in the ISSUE cycle: the operand issued is the old value, i.e. write-after-read.
- Result buffer write and a read of the same slot in the same cycle: rd_* returns the old value.
- cur_idx never exceeds len-1; there is no wrap-around within a batch.
- Arithmetic: none. Pure data movement; widths pass through unchanged.

Optional Feature:
- Macro: AFFINE_BATCH_SEQ_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - If TO_CYCLES cycles elapse without eng_done: set err=1, done=1, irq=1, and go to IDLE.
  - The counter resets on each ISSUE.
- Undefined: no counter; WAIT waits indefinitely. err is set only by abort or an invalid length.

Test Plan:
- Load 3 points (0x0100,0x0200), (-0x0080,0x0040), (0x7FFF,0x8000); go, len=3; engine model returns x+1, y+1 after 5 cycles -> results hold (0x0101,0x0201), (-0x007F,0x0041), (0x8000,0x8001); exactly 3 eng_start pulses; irq is a single pulse; done=1; err=0.
- go with len=0, then with len=DEPTH+1 -> no eng_start; done=1; err=1 in both cases.
- len=4, abort asserted during WAIT of idx 2 -> busy=0 next cycle; err=1; done=0; results 0..1 valid; a late eng_done does not alter result[2].
- go pulsed during busy, plus eng_done injected while IDLE -> no second batch; no spurious result writes.
- len=DEPTH with 0-latency-capable engine (done 1 cycle after start) -> all DEPTH results correct; 2 cycles/point plus FINISH.
- With the macro defined, TO_CYCLES=64, engine never responds -> err=1, done=1, irq pulse exactly 64 cycles after eng_start. Without the macro -> busy stays 1.

Source files
------------

// File: rtl/affine_batch_seq.sv
// affine_batch_seq: batch scheduler for the shared fixed-point affine engine.
// Holds up to DEPTH points, issues them one at a time over a start/done
// handshake and stores each engine result at the matching slot index.
// Optional engine timeout is compiled in with AFFINE_BATCH_SEQ_TIMEOUT_EN.
module affine_batch_seq #(
    parameter int DEPTH     = 8,
    parameter int W         = 16,
    parameter int TO_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pt_we,
    input  logic [$clog2(DEPTH)-1:0] pt_idx,
    input  logic [W-1:0]             pt_x,
    input  logic [W-1:0]             pt_y,
    input  logic [$clog2(DEPTH):0]   batch_len,
    input  logic                     go,
    input  logic                     abort,
    output logic                     eng_start,
    output logic [W-1:0]             eng_x,
    output logic [W-1:0]             eng_y,
    input  logic                     eng_done,
    input  logic [W-1:0]             eng_ox,
    input  logic [W-1:0]             eng_oy,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [W-1:0]             rd_x,
    output logic [W-1:0]             rd_y,
    output logic                     busy,
    output logic [$clog2(DEPTH)-1:0] cur_idx,
    output logic                     done,
    output logic                     irq,
    output logic                     err
);

    localparam int IW = $clog2(DEPTH);
    localparam int LW = IW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FINISH
    } state_t;

    state_t state_q, state_nxt;

    logic [LW-1:0] len_q;
    logic [IW-1:0] cur_q;
    logic [W-1:0]  op_x_q, op_y_q;
    logic          done_q, irq_q, err_q;

    logic [W-1:0]  pt_x_mem  [DEPTH];
    logic [W-1:0]  pt_y_mem  [DEPTH];
    logic [W-1:0]  res_x_mem [DEPTH];
    logic [W-1:0]  res_y_mem [DEPTH];

    logic go_ok, go_bad, abort_hit, res_we, last_pt, finish_set, to_fire;
    logic timeout_hit;

`ifdef AFFINE_BATCH_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYCLES + 1);
    logic [TW-1:0] to_cnt_q;

    // Counts cycles since the current ISSUE; restarts on every issue
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else if (state_q == S_ISSUE) begin
            to_cnt_q <= TW'(1);
        end else if (state_q == S_WAIT) begin
            to_cnt_q <= to_cnt_q + TW'(1);
        end
    end

    assign timeout_hit = (state_q == S_WAIT) && (to_cnt_q == TW'(TO_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state logic and one-cycle control strobes for the register block
    always_comb begin
        state_nxt  = state_q;
        go_ok      = 1'b0;
        go_bad     = 1'b0;
        abort_hit  = 1'b0;
        res_we     = 1'b0;
        finish_set = 1'b0;
        to_fire    = 1'b0;
        last_pt    = ({1'b0, cur_q} == (len_q - LW'(1)));
        case (state_q)
            S_IDLE: begin
                if (go && !abort) begin
                    if ((batch_len != '0) && (batch_len <= DEPTH_L)) begin
                        go_ok     = 1'b1;
                        state_nxt = S_ISSUE;
                    end else begin
                        go_bad = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    abort_hit = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    abort_hit = 1'b1;
                    state_nxt = S_IDLE;
                end else if (eng_done) begin
                    res_we = 1'b1;
                    if (last_pt) begin
                        finish_set = 1'b1;
                        state_nxt  = S_FINISH;
                    end else begin
                        state_nxt = S_ISSUE;
                    end
                end else if (timeout_hit) begin
                    to_fire   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_FINISH: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, index, length, operand hold and status flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            len_q   <= '0;
            op_x_q  <= '0;
            op_y_q  <= '0;
            done_q  <= 1'b0;
            irq_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            irq_q   <= 1'b0;
            if (go_ok) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
                len_q  <= batch_len;
                cur_q  <= '0;
            end
            if (go_bad || to_fire) begin
                done_q <= 1'b1;
                irq_q  <= 1'b1;
                err_q  <= 1'b1;
            end
            if (state_q == S_ISSUE) begin
                op_x_q <= pt_x_mem[cur_q];
                op_y_q <= pt_y_mem[cur_q];
            end
            if (abort_hit) begin
                err_q <= 1'b1;
                cur_q <= '0;
            end
            if (res_we && !last_pt) begin
                cur_q <= cur_q + IW'(1);
            end
            if (finish_set || to_fire) begin
                cur_q <= '0;
            end
            if (finish_set) begin
                done_q <= 1'b1;
                irq_q  <= 1'b1;
            end
        end
    end

    // Point buffer: software writes are accepted at any time
    always_ff @(posedge clk) begin
        if (pt_we) begin
            pt_x_mem[pt_idx] <= pt_x;
            pt_y_mem[pt_idx] <= pt_y;
        end
    end

    // Result buffer: one engine result per accepted eng_done
    always_ff @(posedge clk) begin
        if (res_we) begin
            res_x_mem[cur_q] <= eng_ox;
            res_y_mem[cur_q] <= eng_oy;
        end
    end

    // Operands come straight from the buffer in ISSUE, then from the hold register
    always_comb begin
        eng_x = op_x_q;
        eng_y = op_y_q;
        if (state_q == S_ISSUE) begin
            eng_x = pt_x_mem[cur_q];
            eng_y = pt_y_mem[cur_q];
        end
    end

    assign eng_start = (state_q == S_ISSUE);
    assign busy      = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign cur_idx   = cur_q;
    assign done      = done_q;
    assign irq       = irq_q;
    assign err       = err_q;
    assign rd_x      = res_x_mem[rd_idx];
    assign rd_y      = res_y_mem[rd_idx];

endmodule
